// File: rtl/spi_pkg.sv
// +------------------------------------------------------------------+
// | spi_pkg : shared types and constants for the SPI transfer queue   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

package spi_pkg;

   localparam int SPI_DW = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      WAIT    = 2'd2,
      CAPTURE = 2'd3
   } spi_state_e;

endpackage

`default_nettype wire

// File: rtl/spi_sync_fifo.sv
// +------------------------------------------------------------------+
// | spi_sync_fifo : single-clock FIFO, zero-latency head, level count |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module spi_sync_fifo #(
   parameter int DEPTH = 4,
   parameter int DW    = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic [DW-1:0]          push_data,
   input  logic                   pop,
   output logic [DW-1:0]          head,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);

   localparam int AW = $clog2(DEPTH);

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   level_q, level_d;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
         2'b10:   level_d = level_q + (AW+1)'(1);
         2'b01:   level_d = level_q - (AW+1)'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   assign head  = mem_q[rd_ptr_q];
   assign full  = (level_q == (AW+1)'(DEPTH));
   assign empty = (level_q == '0);
   assign level = level_q;

endmodule

`default_nettype wire

// File: rtl/spi_xfer_queue.sv
// +------------------------------------------------------------------+
// | spi_xfer_queue : TX/RX byte queue sequencing an SPI master        |
// | Option macro SPI_XFER_QUEUE_RX_EN adds the RX FIFO path. Rev 1.0  |
// +------------------------------------------------------------------+
`default_nettype none

module spi_xfer_queue
   import spi_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int DW    = SPI_DW
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_valid,
   input  logic [DW-1:0]          wr_data,
   output logic                   wr_ready,
   output logic                   rd_valid,
   output logic [DW-1:0]          rd_data,
   input  logic                   rd_ready,
   output logic                   m_start,
   output logic [DW-1:0]          m_data_in,
   input  logic                   m_done,
   input  logic [DW-1:0]          m_data_out,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] tx_level,
   output logic [$clog2(DEPTH):0] rx_level
);

   spi_state_e    state_q, state_d;
   logic [DW-1:0] hold_q, hold_d;
   logic          m_start_q, m_start_d;
   logic          tx_full, tx_empty, tx_pop;
   logic [DW-1:0] tx_head;
   logic          rx_room;

   spi_sync_fifo #(.DEPTH(DEPTH), .DW(DW)) u_tx_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (wr_valid && wr_ready),
      .push_data (wr_data),
      .pop       (tx_pop),
      .head      (tx_head),
      .full      (tx_full),
      .empty     (tx_empty),
      .level     (tx_level)
   );

   assign wr_ready = !tx_full;

`ifdef SPI_XFER_QUEUE_RX_EN
   logic [DW-1:0] cap_q, cap_d;
   logic          rx_push, rx_full, rx_empty;

   spi_sync_fifo #(.DEPTH(DEPTH), .DW(DW)) u_rx_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (rx_push),
      .push_data (cap_q),
      .pop       (rd_valid && rd_ready),
      .head      (rd_data),
      .full      (rx_full),
      .empty     (rx_empty),
      .level     (rx_level)
   );

   assign rd_valid = !rx_empty;
   // Only the FSM fills RX, so a free slot now is still free at CAPTURE.
   assign rx_room  = !rx_full;
`else
   logic unused_rx;

   assign rd_valid  = 1'b0;
   assign rd_data   = '0;
   assign rx_level  = '0;
   assign rx_room   = 1'b1;
   assign unused_rx = ^{rd_ready, m_data_out};
`endif

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      tx_pop  = 1'b0;
`ifdef SPI_XFER_QUEUE_RX_EN
      cap_d   = cap_q;
      rx_push = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (!tx_empty && rx_room) begin
               tx_pop  = 1'b1;
               hold_d  = tx_head;
               state_d = ISSUE;
            end
         end
         ISSUE: state_d = WAIT;
         WAIT: begin
            if (m_done) begin
`ifdef SPI_XFER_QUEUE_RX_EN
               cap_d   = m_data_out;
               state_d = CAPTURE;
`else
               state_d = IDLE;
`endif
            end
         end
         CAPTURE: begin
`ifdef SPI_XFER_QUEUE_RX_EN
            rx_push = 1'b1;
`endif
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      m_start_d = (state_d == ISSUE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         hold_q    <= '0;
         m_start_q <= 1'b0;
`ifdef SPI_XFER_QUEUE_RX_EN
         cap_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         hold_q    <= hold_d;
         m_start_q <= m_start_d;
`ifdef SPI_XFER_QUEUE_RX_EN
         cap_q     <= cap_d;
`endif
      end
   end

   // The holding register doubles as the master data bus, so it holds between transfers.
   assign m_start   = m_start_q;
   assign m_data_in = hold_q;
   assign busy      = (state_q != IDLE) || (tx_level != '0);

endmodule

`default_nettype wire
